// File: rtl/sram_bus_arbiter_pkg.sv
// ============================================================================
// Module      : sram_bus_arbiter_pkg
// Description : Shared encodings and bus widths for the SRAM bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_bus_arbiter_pkg;

  localparam int C_BUS_ADDR_W = 32;
  localparam int C_BUS_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  localparam logic GNT_INST = 1'b0;
  localparam logic GNT_DATA = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sram_arb_pick.sv
// ============================================================================
// Module      : sram_arb_pick
// Description : Winner selection (data first) with a fetch starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arb_pick
  import sram_bus_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inst_req,
  input  logic i_data_req,
  input  logic i_idle,
  output logic o_accept,
  output logic o_grant_next
);

  logic [3:0] r_starve_cnt;
  logic       w_force_inst;

  assign w_force_inst = i_inst_req && (r_starve_cnt == 4'(STARVE_MAX));
  assign o_grant_next = (i_data_req && !w_force_inst) ? GNT_DATA : GNT_INST;
  assign o_accept     = i_idle && (i_inst_req || i_data_req);

  // Only IDLE cycles move the counter; with fetch waiting, IDLE always accepts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (i_idle) begin
      if (!i_inst_req || (o_grant_next == GNT_INST)) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt < 4'(STARVE_MAX)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_bus_arbiter.sv
// ============================================================================
// Module      : sram_bus_arbiter
// Description : Shares one sram-like bus between fetch and load/store ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = C_BUS_ADDR_W,
  parameter int DATA_W     = C_BUS_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        r_state;
  logic              r_grant;
  logic              r_wr;
  logic [3:0]        r_wstrb;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic w_idle;
  logic w_accept;
  logic w_grant_next;
  logic w_done;

  // Qualifying with reset keeps the combinational addr_ok pulses quiet in reset.
  assign w_idle = rst && (r_state == ARB_IDLE);

  sram_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk          (clk),
    .rst          (rst),
    .i_inst_req   (inst_req),
    .i_data_req   (data_req),
    .i_idle       (w_idle),
    .o_accept     (w_accept),
    .o_grant_next (w_grant_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ARB_IDLE;
      r_grant <= GNT_INST;
      r_wr    <= 1'b0;
      r_wstrb <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_accept) begin
            r_grant <= w_grant_next;
            r_state <= ARB_ADDR;
            if (w_grant_next == GNT_DATA) begin
              r_wr    <= data_wr;
              r_wstrb <= data_wstrb;
              r_addr  <= data_addr;
              r_wdata <= data_wdata;
            end else begin
              r_wr    <= 1'b0;
              r_wstrb <= '0;
              r_addr  <= inst_addr;
              r_wdata <= '0;
            end
          end
        end
        ARB_ADDR: begin
          if (mem_addr_ok) begin
            r_state <= mem_data_ok ? ARB_IDLE : ARB_DATA;
          end
        end
        ARB_DATA: begin
          if (mem_data_ok) begin
            r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign w_done = ((r_state == ARB_ADDR) && mem_addr_ok && mem_data_ok) ||
                  ((r_state == ARB_DATA) && mem_data_ok);

  assign inst_addr_ok = w_accept && (w_grant_next == GNT_INST);
  assign data_addr_ok = w_accept && (w_grant_next == GNT_DATA);

  assign inst_data_ok = w_done && (r_grant == GNT_INST);
  assign data_data_ok = w_done && (r_grant == GNT_DATA);
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;

  assign mem_req   = (r_state == ARB_ADDR);
  assign mem_wr    = r_wr;
  assign mem_wstrb = r_wstrb;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
// ============================================================================
// Module      : tb_sram_bus_arbiter
// Description : Scoreboard bench for sram_bus_arbiter with a scripted memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_bus_arbiter;

  typedef struct {
    logic gnt;
    int   cyc;
  } acc_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mreq_t;

  typedef struct {
    logic        gnt;
    logic [31:0] rdata;
    int          cyc;
  } rsp_t;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  sram_bus_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  acc_t        exp_acc[$];
  mreq_t       exp_mem[$];
  rsp_t        exp_rsp[$];
  logic [31:0] inst_q[$];
  mreq_t       data_q[$];

  int cyc       = 0;
  int n_chk     = 0;
  int n_fail    = 0;
  int addr_dly  = 0;
  int data_dly  = 0;
  int spur_req  = 0;
  int spur_done = 0;
  bit done      = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: actual run still active, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_model(input logic [31:0] a, input logic wr);
    if (wr) return 32'h0;
    case (a)
      32'hBFC0_0000: return 32'h3C1D_BFC0;
      32'h8000_2000: return 32'h1234_5678;
      default:       return ~a;
    endcase
  endfunction

  // Memory: mem_addr_ok after addr_dly cycles of mem_req, mem_data_ok data_dly later.
  initial begin
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    forever begin
      @(posedge clk); #1;
      if (rst && mem_req) begin
        repeat (addr_dly) begin @(posedge clk); #1; end
        mem_addr_ok = 1'b1;
        if (data_dly == 0) begin
          mem_data_ok = 1'b1;
          mem_rdata   = mem_model(mem_addr, mem_wr);
        end
        @(posedge clk); #1;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = '0;
        if (data_dly > 0) begin
          repeat (data_dly - 1) begin @(posedge clk); #1; end
          mem_data_ok = 1'b1;
          mem_rdata   = mem_model(mem_addr, mem_wr);
          @(posedge clk); #1;
          mem_data_ok = 1'b0;
          mem_rdata   = '0;
        end
      end else if (!mem_req && spur_req != spur_done) begin
        spur_done++;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = '0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic fail(input string msg);
    n_fail++;
    $display("FAIL %s", msg);
  endtask

  acc_t  m_acc;
  mreq_t m_req;
  rsp_t  m_rsp;

  always @(negedge clk) begin
    if (!rst) begin
      n_chk++;
      if ({inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
           mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata} != '0)
        fail($sformatf("reset_outputs: cycle %0d actual mem_req=%0b mem_addr=%h inst_addr_ok=%0b data_addr_ok=%0b, required all zero",
                       cyc, mem_req, mem_addr, inst_addr_ok, data_addr_ok));
    end else begin
      if (inst_addr_ok || data_addr_ok) begin
        n_chk++;
        if (exp_acc.size() == 0 || (inst_addr_ok && data_addr_ok)) begin
          fail($sformatf("accept: cycle %0d actual inst_addr_ok=%0b data_addr_ok=%0b, required no accept",
                         cyc, inst_addr_ok, data_addr_ok));
        end else begin
          m_acc = exp_acc.pop_front();
          if (data_addr_ok != m_acc.gnt || cyc != m_acc.cyc)
            fail($sformatf("accept: actual data=%0b at cycle %0d, required data=%0b at cycle %0d",
                           data_addr_ok, cyc, m_acc.gnt, m_acc.cyc));
        end
      end

      if (mem_req) begin
        n_chk++;
        if (exp_mem.size() == 0) begin
          fail($sformatf("mem_req: cycle %0d actual mem_req=1 addr=%h, required mem_req=0", cyc, mem_addr));
        end else begin
          m_req = exp_mem[0];
          if (mem_addr != m_req.addr || mem_wr != m_req.wr ||
              mem_wstrb != m_req.wstrb || mem_wdata != m_req.wdata)
            fail($sformatf("mem_fields: cycle %0d actual addr=%h wr=%0b wstrb=%h wdata=%h, required addr=%h wr=%0b wstrb=%h wdata=%h",
                           cyc, mem_addr, mem_wr, mem_wstrb, mem_wdata,
                           m_req.addr, m_req.wr, m_req.wstrb, m_req.wdata));
          if (mem_addr_ok) void'(exp_mem.pop_front());
        end
      end

      if (inst_data_ok || data_data_ok) begin
        n_chk++;
        if (exp_rsp.size() == 0 || (inst_data_ok && data_data_ok)) begin
          fail($sformatf("data_ok: cycle %0d actual inst_data_ok=%0b data_data_ok=%0b, required no response",
                         cyc, inst_data_ok, data_data_ok));
        end else begin
          m_rsp = exp_rsp.pop_front();
          if (data_data_ok != m_rsp.gnt || cyc != m_rsp.cyc ||
              (data_data_ok ? data_rdata : inst_rdata) != m_rsp.rdata ||
              (data_data_ok ? inst_rdata : data_rdata) != 32'h0)
            fail($sformatf("response: actual data=%0b cycle %0d inst_rdata=%h data_rdata=%h, required data=%0b cycle %0d rdata=%h",
                           data_data_ok, cyc, inst_rdata, data_rdata,
                           m_rsp.gnt, m_rsp.cyc, m_rsp.rdata));
        end
      end else begin
        n_chk++;
        if (inst_rdata != 32'h0 || data_rdata != 32'h0)
          fail($sformatf("idle_rdata: cycle %0d actual inst_rdata=%h data_rdata=%h, required 0",
                         cyc, inst_rdata, data_rdata));
      end
    end

    if (done) begin
      n_chk++;
      if (exp_acc.size() != 0 || exp_mem.size() != 0 || exp_rsp.size() != 0)
        fail($sformatf("leftover: actual %0d accepts %0d mem %0d responses pending, required 0 0 0",
                       exp_acc.size(), exp_mem.size(), exp_rsp.size()));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  task automatic exp_txn(input logic gnt, input logic [31:0] addr, input logic wr,
                         input logic [3:0] wstrb, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int acc_cyc, input int rsp_cyc);
    exp_acc.push_back('{gnt, acc_cyc});
    exp_mem.push_back('{addr, wr, wstrb, wdata});
    exp_rsp.push_back('{gnt, rdata, rsp_cyc});
  endtask

  task automatic step();
    logic  a_i;
    logic  a_d;
    mreq_t d;
    @(negedge clk);
    a_i = inst_addr_ok;
    a_d = data_addr_ok;
    @(posedge clk); #1;
    if (a_i) inst_req = 1'b0;
    if (a_d) data_req = 1'b0;
    if (!inst_req && inst_q.size() > 0) begin
      inst_req  = 1'b1;
      inst_addr = inst_q.pop_front();
    end
    if (!data_req && data_q.size() > 0) begin
      d          = data_q.pop_front();
      data_req   = 1'b1;
      data_addr  = d.addr;
      data_wr    = d.wr;
      data_wstrb = d.wstrb;
      data_wdata = d.wdata;
    end
  endtask

  task automatic drain(input int max_steps);
    int n;
    n = 0;
    while ((exp_acc.size() != 0 || exp_rsp.size() != 0 || exp_mem.size() != 0 ||
            inst_q.size() != 0 || data_q.size() != 0 || inst_req || data_req) &&
           n < max_steps) begin
      step();
      n++;
    end
    step();
    step();
  endtask

  int c;

  initial begin
    rst        = 1'b0;
    inst_req   = 1'b1;
    inst_addr  = 32'hBFC0_0000;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_wstrb = '0;
    data_addr  = '0;
    data_wdata = '0;
    addr_dly   = 0;
    data_dly   = 2;

    // Single fetch, request already pending across reset release
    repeat (3) step();
    rst = 1'b1;
    c = cyc;
    exp_txn(1'b0, 32'hBFC0_0000, 1'b0, 4'h0, 32'h0, 32'h3C1D_BFC0, c, c + 3);
    drain(40);

    // Simultaneous requests: data store first, fetch right after
    data_dly = 1;
    inst_q.push_back(32'hBFC0_0010);
    data_q.push_back('{32'h8000_1000, 1'b1, 4'hF, 32'hDEAD_BEEF});
    step();
    c = cyc;
    exp_txn(1'b1, 32'h8000_1000, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0, c, c + 2);
    exp_txn(1'b0, 32'hBFC0_0010, 1'b0, 4'h0, 32'h0, ~32'hBFC0_0010, c + 3, c + 5);
    drain(40);

    // Starvation: 4 data grants, then fetch, then data resumes
    for (int i = 0; i < 6; i++) data_q.push_back('{32'h8000_0100 + 32'(4 * i), 1'b0, 4'h0, 32'h0});
    inst_q.push_back(32'hBFC0_0020);
    step();
    c = cyc;
    for (int i = 0; i < 4; i++)
      exp_txn(1'b1, 32'h8000_0100 + 32'(4 * i), 1'b0, 4'h0, 32'h0, ~(32'h8000_0100 + 32'(4 * i)),
              c + 3 * i, c + 3 * i + 2);
    exp_txn(1'b0, 32'hBFC0_0020, 1'b0, 4'h0, 32'h0, ~32'hBFC0_0020, c + 12, c + 14);
    exp_txn(1'b1, 32'h8000_0110, 1'b0, 4'h0, 32'h0, ~32'h8000_0110, c + 15, c + 17);
    exp_txn(1'b1, 32'h8000_0114, 1'b0, 4'h0, 32'h0, ~32'h8000_0114, c + 18, c + 20);
    drain(80);

    // addr_ok and data_ok in the same cycle; fetch proves IDLE the next cycle
    data_dly = 0;
    data_q.push_back('{32'h8000_2000, 1'b0, 4'h0, 32'h0});
    inst_q.push_back(32'hBFC0_0030);
    step();
    c = cyc;
    exp_txn(1'b1, 32'h8000_2000, 1'b0, 4'h0, 32'h0, 32'h1234_5678, c, c + 1);
    exp_txn(1'b0, 32'hBFC0_0030, 1'b0, 4'h0, 32'h0, ~32'hBFC0_0030, c + 2, c + 3);
    drain(40);

    // Slow memory: addr_ok after 6 cycles of mem_req, second store waits
    addr_dly = 5;
    data_dly = 1;
    data_q.push_back('{32'h8000_3000, 1'b1, 4'h3, 32'h0BAD_F00D});
    data_q.push_back('{32'h8000_3004, 1'b0, 4'h0, 32'h0});
    step();
    c = cyc;
    exp_txn(1'b1, 32'h8000_3000, 1'b1, 4'h3, 32'h0BAD_F00D, 32'h0, c, c + 7);
    exp_txn(1'b1, 32'h8000_3004, 1'b0, 4'h0, 32'h0, ~32'h8000_3004, c + 8, c + 15);
    drain(60);

    // Reset while in DATA; the late memory response must be dropped
    addr_dly = 0;
    data_dly = 6;
    data_q.push_back('{32'h8000_4000, 1'b0, 4'h0, 32'h0});
    step();
    c = cyc;
    exp_acc.push_back('{1'b1, c});
    exp_mem.push_back('{32'h8000_4000, 1'b0, 4'h0, 32'h0});
    step();
    step();
    rst = 1'b0;
    step();
    step();
    rst       = 1'b1;
    data_dly  = 1;
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0040;
    exp_txn(1'b0, 32'hBFC0_0040, 1'b0, 4'h0, 32'h0, ~32'hBFC0_0040, c + 4, c + 10);
    drain(40);

    // Spurious memory handshake while IDLE
    spur_req++;
    repeat (4) step();

    done = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL finish: actual monitor did not end the run, required summary");
    $fatal(1, "monitor did not finish");
  end

endmodule

`default_nettype wire
